// File: rtl/counter.sv
// Free-running unsigned up-counter, modulo 2^WIDTH.
// Asynchronous active-low clear; output comes straight from the state register.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    // Carry-out is dropped so the all-ones value rolls over to zero.
    assign w_next = r_count + WIDTH'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_counter.sv
// Directed table-driven bench for counter (WIDTH=4).
// Covers power-on reset, wrap, mid-count and all-ones clear.
`timescale 1ns/1ps
module tb_counter;

    logic       clock;
    logic       reset;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    counter #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .count (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: count=%0d expected=%0d",
                     name, $time, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Entry i is applied at the falling edge before the i-th rising edge.
        tbl[0]  = '{1'b0, 4'd0};
        tbl[1]  = '{1'b1, 4'd1};
        tbl[2]  = '{1'b1, 4'd2};
        tbl[3]  = '{1'b1, 4'd3};
        tbl[4]  = '{1'b1, 4'd4};
        tbl[5]  = '{1'b1, 4'd5};
        tbl[6]  = '{1'b1, 4'd6};
        tbl[7]  = '{1'b1, 4'd7};
        tbl[8]  = '{1'b1, 4'd8};
        tbl[9]  = '{1'b1, 4'd9};
        tbl[10] = '{1'b1, 4'd10};
        tbl[11] = '{1'b1, 4'd11};
        tbl[12] = '{1'b1, 4'd12};
        tbl[13] = '{1'b1, 4'd13};
        tbl[14] = '{1'b1, 4'd14};
        tbl[15] = '{1'b1, 4'd15};
        tbl[16] = '{1'b1, 4'd0};
        tbl[17] = '{1'b1, 4'd1};
        tbl[18] = '{1'b1, 4'd2};
        tbl[19] = '{1'b1, 4'd3};
        tbl[20] = '{1'b1, 4'd4};

        reset = 1'b0;
        #2;
        chk("por_async", count, 4'd0);

        for (int i = 0; i < 21; i++) begin
            reset = tbl[i].rst;
            @(posedge clock);
            #1;
            chk($sformatf("seq1_v%0d", i), count, tbl[i].exp);
            @(negedge clock);
        end

        chk("hold_210ns", count, 4'd4);
        reset = 1'b0;
        #1;
        chk("midcount_async_clr", count, 4'd0);
        @(posedge clock);
        #1;
        chk("edge_ignored_in_rst", count, 4'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("release_no_change", count, 4'd0);

        for (int i = 1; i <= 15; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("seq2_%0d", i), count, 4'(i));
        end

        #2;
        reset = 1'b0;
        #1;
        chk("clr_at_all_ones", count, 4'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("release_after_ones", count, 4'd0);
        @(posedge clock);
        #1;
        chk("first_after_ones", count, 4'd1);
        @(posedge clock);
        #1;
        chk("second_after_ones", count, 4'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the count output and internal register.
REQ-002 Port: clock  input  1  single clock; all state changes on the rising edge except reset.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; low forces count to zero immediately.
REQ-004 Port: count  output  WIDTH  current counter value, driven directly from a register.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset; no other clocks, enables or resets.
REQ-006 Ports SHALL be declared in the order clock, reset, count so that positional instantiation binds correctly.

Function
REQ-007 Rising clock edge with reset high: count SHALL become (count + 1) mod 2^WIDTH.
REQ-008 Increment latency: new value visible on count immediately after the triggering rising edge; one increment per edge, no skipped or repeated values.
REQ-009 Wrap-around: at count = 2^WIDTH-1 (15 for WIDTH=4), the next edge SHALL produce 0 with no stall, flag or saturation.
REQ-010 Arithmetic SHALL be unsigned modulo 2^WIDTH; the carry-out is discarded.
REQ-011 count SHALL be a registered output with no combinational path from any input except the asynchronous clear from reset.
REQ-012 Undefined inputs (X/Z on clock before first edge) SHALL NOT matter once reset has been asserted; after reset count SHALL be a known value.

Reset
REQ-013 reset falling to 0 SHALL set count to 0 immediately, independent of clock.
REQ-014 While reset is 0, rising clock edges SHALL be ignored; count SHALL hold 0.
REQ-015 reset rising to 1 SHALL NOT itself change count; the first increment occurs on the first rising clock edge strictly after release (count 0 -> 1).
REQ-016 Reset asserted mid-count (any value, including 2^WIDTH-1) SHALL clear to 0 with the same behaviour as power-on reset.
REQ-017 Reset value of every output: count = 0.

Verification
REQ-018 Clock period 10 ns (toggle every 5 ns, starting low); reset low 0-10 ns -> count = 0 throughout, edge at 5 ns ignored.
REQ-019 Reset released at 10 ns, run 200 ns (rising edges 15..205 ns, 20 edges) -> count sequence 1,2,...,15,0,1,2,3,4; count = 4 at 210 ns.
REQ-020 Wrap check: edge at 155 ns -> count 15; edge at 165 ns -> count 0.
REQ-021 Reset asserted at 210 ns with count = 4 -> count = 0 immediately (before next edge); edge at 215 ns while reset low -> count stays 0.
REQ-022 Reset released at 220 ns, run 100 ns (edges 225..315 ns) -> count 1..10; count = 10 at 320 ns.
REQ-023 Reset asserted at count = 15, then released -> count 0, then first subsequent rising edge gives 1.
